// File: rtl/rx_buff_wr_pkg.sv
// rx_buff_wr shared types: FSM states, descriptor layout, byte helpers.
package rx_buff_wr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    DESC = 2'd2,
    DROP = 2'd3
  } state_t;

  localparam int LEN_LSB = 0;
  localparam int LEN_MSB = 15;

  function automatic logic [3:0] popcnt8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b0, v[i]};
    return n;
  endfunction

  function automatic logic [63:0] make_desc(input logic [15:0] len);
    logic [63:0] d;
    d = '0;
    d[LEN_MSB:LEN_LSB] = len;
    return d;
  endfunction

endpackage

// File: rtl/rx_buff_wr_free.sv
// rx_buff_wr free-space check: would the next data word
// overrun the space the reader has released?
module rx_buff_wr_free
  import rx_buff_wr_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic [AW-1:0] cons_ptr,
  input  logic [AW-1:0] slot,
  input  logic [AW-1:0] off,
  output logic          ovf
);

  logic [AW-1:0] free;
  logic [AW:0]   need;

  // One slot short of cons_ptr stays free.
  assign free = cons_ptr - slot - AW'(1);
  assign need = {1'b0, off} + {{AW{1'b0}}, 1'b1};
  assign ovf  = need > {1'b0, free};

endmodule

// File: rtl/rx_buff_wr.sv
// rx_buff_wr: packs MAC receive frames into the receive buffer.
// Define RX_BUFF_WR_STATS_EN for live good/dropped frame counters.
module rx_buff_wr
  import rx_buff_wr_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [63:0]   rx_data,
  input  logic [7:0]    rx_data_valid,
  input  logic          rx_good_frame,
  input  logic          rx_bad_frame,
  input  logic [AW-1:0] cons_ptr,
  output logic [AW-1:0] wr_addr,
  output logic [63:0]   wr_data,
  output logic [AW-1:0] commit_ptr,
  output logic          frame_committed,
  output logic [31:0]   good_frames,
  output logic [31:0]   dropped_frames
);

  state_t        state, state_n;
  logic [AW-1:0] slot, slot_n;
  logic [AW-1:0] off, off_n;
  logic [15:0]   len, len_n;
  logic [15:0]   bytes;
  logic [AW-1:0] addr_n;
  logic [63:0]   data_n;
  logic          word, ended, ovf;
  logic          drop_end, desc_go;
  logic          p1_v, p2_v;
  logic [AW-1:0] p1_ptr, p2_ptr;

  assign word  = |rx_data_valid;
  assign ended = rx_good_frame | rx_bad_frame;
  assign bytes = 16'(popcnt8(rx_data_valid));

  rx_buff_wr_free #(.AW(AW)) u_free (
    .cons_ptr (cons_ptr),
    .slot     (slot),
    .off      (off),
    .ovf      (ovf)
  );

  always_comb begin
    state_n  = state;
    slot_n   = slot;
    off_n    = off;
    len_n    = len;
    addr_n   = slot;
    data_n   = rx_data;
    drop_end = 1'b0;
    desc_go  = 1'b0;
    unique case (state)
      IDLE, DATA: begin
        if (word && ovf) begin
          if (ended) drop_end = 1'b1;
          else       state_n  = DROP;
        end else begin
          if (word) begin
            addr_n  = slot + AW'(1) + off;
            off_n   = off + AW'(1);
            len_n   = len + bytes;
            state_n = DATA;
          end
          if (word || state == DATA) begin
            if (rx_bad_frame)       drop_end = 1'b1;
            else if (rx_good_frame) state_n  = DESC;
          end
        end
      end
      DESC: begin
        data_n  = make_desc(len);
        slot_n  = slot + AW'(1) + off;
        desc_go = 1'b1;
        state_n = IDLE;
        // A word here cannot be placed; that frame is lost.
        if (word) begin
          if (ended) drop_end = 1'b1;
          else       state_n  = DROP;
        end
      end
      DROP: begin
        if (ended) drop_end = 1'b1;
      end
      default: ;
    endcase
    if (drop_end) state_n = IDLE;
    if (state_n == IDLE) begin
      off_n = '0;
      len_n = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= IDLE;
      slot            <= '0;
      off             <= '0;
      len             <= '0;
      wr_addr         <= '0;
      wr_data         <= '0;
      p1_v            <= 1'b0;
      p1_ptr          <= '0;
      p2_v            <= 1'b0;
      p2_ptr          <= '0;
      commit_ptr      <= '0;
      frame_committed <= 1'b0;
    end else begin
      state           <= state_n;
      slot            <= slot_n;
      off             <= off_n;
      len             <= len_n;
      wr_addr         <= addr_n;
      wr_data         <= data_n;
      // Publish only once the descriptor has reached the RAM.
      p1_v            <= desc_go;
      p1_ptr          <= slot_n;
      p2_v            <= p1_v;
      p2_ptr          <= p1_ptr;
      frame_committed <= p2_v;
      if (p2_v) commit_ptr <= p2_ptr;
    end
  end

`ifdef RX_BUFF_WR_STATS_EN
  logic [31:0] good_cnt, drop_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      good_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (p2_v)     good_cnt <= good_cnt + 32'd1;
      if (drop_end) drop_cnt <= drop_cnt + 32'd1;
    end
  end

  assign good_frames    = good_cnt;
  assign dropped_frames = drop_cnt;
`else
  assign good_frames    = '0;
  assign dropped_frames = '0;
`endif

endmodule

// File: tb/tb_rx_buff_wr.sv
// Testbench for rx_buff_wr: frame-level reference model,
// shadow buffer RAM, per-cycle commit/counter comparison.
module tb_rx_buff_wr;
  localparam int AW = 10;
  localparam int N  = 1 << AW;
`ifdef RX_BUFF_WR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [63:0]   rx_data;
  logic [7:0]    rx_data_valid;
  logic          rx_good_frame;
  logic          rx_bad_frame;
  logic [AW-1:0] cons_ptr;
  logic [AW-1:0] wr_addr;
  logic [63:0]   wr_data;
  logic [AW-1:0] commit_ptr;
  logic          frame_committed;
  logic [31:0]   good_frames;
  logic [31:0]   dropped_frames;

  always #5 clk = ~clk;

  rx_buff_wr #(.AW(AW)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .rx_data         (rx_data),
    .rx_data_valid   (rx_data_valid),
    .rx_good_frame   (rx_good_frame),
    .rx_bad_frame    (rx_bad_frame),
    .cons_ptr        (cons_ptr),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .commit_ptr      (commit_ptr),
    .frame_committed (frame_committed),
    .good_frames     (good_frames),
    .dropped_frames  (dropped_frames)
  );

  logic [63:0] ram [N];
  always @(posedge clk) ram[wr_addr] <= wr_data;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;
  int n_pulse = 0;
  bit run = 1'b0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)",
                  nm, act, want, cyc);
  endtask

  // Frame-level model
  typedef struct {
    int cyc;
    int ptr;
    int slot;
    int n;
  } cev_t;

  logic [63:0] exp_mem [N];
  cev_t cq[$];
  int   dq[$];
  int   m_slot = 0;
  int   m_commit = 0;
  bit   m_pulse = 1'b0;
  int   m_good = 0;
  int   m_drop = 0;
  int   ps = 0;
  int   pn = -1;

  task automatic verify(input int s, input int n, input string tag);
    for (int i = 0; i <= n; i++)
      check(tag, ram[(s + i) % N], exp_mem[(s + i) % N]);
  endtask

  always @(negedge clk) begin
    if (run) begin
      m_pulse = 1'b0;
      if (cq.size() > 0 && cq[0].cyc == cyc) begin
        m_commit = cq[0].ptr;
        m_pulse  = 1'b1;
        m_good++;
        verify(cq[0].slot, cq[0].n, "frame_words");
        if (pn >= 0) verify(ps, pn, "prev_frame_words");
        ps = cq[0].slot;
        pn = cq[0].n;
        void'(cq.pop_front());
      end
      while (dq.size() > 0 && dq[0] == cyc) begin
        m_drop++;
        void'(dq.pop_front());
      end
      check("commit_ptr", 64'(commit_ptr), 64'(m_commit));
      check("frame_committed", 64'(frame_committed), 64'(m_pulse));
      check("good_frames", 64'(good_frames),
            STATS ? 64'(m_good) : 64'd0);
      check("dropped_frames", 64'(dropped_frames),
            STATS ? 64'(m_drop) : 64'd0);
      if (frame_committed === 1'b1) n_pulse++;
    end
  end

  task automatic clear_in();
    rx_data       = '0;
    rx_data_valid = '0;
    rx_good_frame = 1'b0;
    rx_bad_frame  = 1'b0;
  endtask

  task automatic idle(input int c);
    repeat (c) begin
      @(posedge clk); #1;
      clear_in();
    end
  endtask

  task automatic send_frame(input int n, input int k, input bit bad,
                            input bit both, input int tail);
    logic [63:0] w [$];
    int len, fr, e;
    bit drop;
    len  = 8 * (n - 1) + k;
    fr   = (int'(cons_ptr) - m_slot - 1 + N) % N;
    drop = bad || (n > fr);
    e    = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      clear_in();
      rx_data       = {$urandom, $urandom};
      rx_data_valid = (i == n - 1) ? 8'((1 << k) - 1) : 8'hFF;
      w.push_back(rx_data);
      if (i == n - 1 && tail == 0) begin
        rx_good_frame = !bad || both;
        rx_bad_frame  = bad;
        e = cyc;
      end
    end
    for (int t = 1; t <= tail; t++) begin
      @(posedge clk); #1;
      clear_in();
      if (t == tail) begin
        rx_good_frame = !bad || both;
        rx_bad_frame  = bad;
        e = cyc;
      end
    end
    @(posedge clk); #1;
    clear_in();
    if (drop) dq.push_back(e + 1);
    else begin
      exp_mem[m_slot] = 64'(len);
      for (int i = 0; i < n; i++) exp_mem[(m_slot + 1 + i) % N] = w[i];
      cq.push_back('{e + 4, (m_slot + 1 + n) % N, m_slot, n});
      m_slot = (m_slot + 1 + n) % N;
    end
  endtask

  initial begin
    int p0;
    reset_n  = 1'b0;
    cons_ptr = '0;
    clear_in();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    run = 1'b1;
    @(negedge clk);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_wr_data", wr_data, 64'd0);
    check("rst_commit_ptr", 64'(commit_ptr), 64'd0);
    check("rst_frame_committed", 64'(frame_committed), 64'd0);
    check("rst_good_frames", 64'(good_frames), 64'd0);
    check("rst_dropped_frames", 64'(dropped_frames), 64'd0);

    // 64-byte frame, good pulse after the last word
    p0 = n_pulse;
    send_frame(8, 8, 1'b0, 1'b0, 1);
    idle(6);
    check("f64_commit", 64'(commit_ptr), 64'd9);
    check("f64_desc", ram[0], 64'h40);
    check("f64_pulses", 64'(n_pulse - p0), 64'd1);

    // 61-byte frame, good pulse with the last word
    send_frame(8, 5, 1'b0, 1'b0, 0);
    idle(6);
    check("f61_commit", 64'(commit_ptr), 64'd18);
    check("f61_desc", ram[9], 64'd61);

    // bad frame, then a good frame from the same slot
    send_frame(8, 8, 1'b1, 1'b0, 0);
    idle(3);
    check("bad_commit", 64'(commit_ptr), 64'd18);
    check("bad_dropped", 64'(dropped_frames), STATS ? 64'd1 : 64'd0);
    send_frame(8, 8, 1'b0, 1'b0, 1);
    idle(6);
    check("after_bad_commit", 64'(commit_ptr), 64'd27);
    check("after_bad_desc", ram[18], 64'h40);

    // reset in the middle of a frame
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      clear_in();
      rx_data       = {$urandom, $urandom};
      rx_data_valid = 8'hFF;
    end
    @(posedge clk); #1;
    clear_in();
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n  = 1'b1;
    cons_ptr = '0;
    m_slot = 0; m_commit = 0; m_good = 0; m_drop = 0; pn = -1;
    cq.delete();
    dq.delete();
    @(negedge clk);
    check("mid_rst_wr_addr", 64'(wr_addr), 64'd0);
    check("mid_rst_wr_data", wr_data, 64'd0);
    check("mid_rst_commit_ptr", 64'(commit_ptr), 64'd0);
    check("mid_rst_frame_committed", 64'(frame_committed), 64'd0);
    check("mid_rst_good", 64'(good_frames), 64'd0);
    check("mid_rst_dropped", 64'(dropped_frames), 64'd0);
    send_frame(2, 4, 1'b0, 1'b0, 1);
    idle(6);
    check("post_rst_commit", 64'(commit_ptr), 64'd3);
    check("post_rst_desc", ram[0], 64'd12);

    // advance the slot to 1016 with the reader parked at 0
    for (int i = 0; i < 7; i++) begin
      send_frame(127, 8, 1'b0, 1'b0, 1);
      idle(1);
    end
    send_frame(116, 8, 1'b0, 1'b0, 1);
    idle(6);
    check("fill_commit", 64'(commit_ptr), 64'd1016);

    // 16-word frame overflows with only 7 free words
    send_frame(16, 8, 1'b0, 1'b0, 1);
    idle(6);
    check("ovf_commit", 64'(commit_ptr), 64'd1016);

    // reader releases half the buffer; frame wraps
    cons_ptr = AW'(512);
    send_frame(16, 8, 1'b0, 1'b0, 1);
    idle(6);
    check("wrap_commit", 64'(commit_ptr), 64'd9);
    check("wrap_desc", ram[1016], 64'd128);

    // randomized frames
    for (int f = 0; f < 80; f++) begin
      int n, k, tail;
      bit bad, both;
      n    = $urandom_range(1, 20);
      k    = $urandom_range(1, 8);
      bad  = ($urandom_range(0, 4) == 0);
      both = ($urandom_range(0, 1) == 1);
      tail = $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0)
        cons_ptr = AW'((m_slot + $urandom_range(1, 24)) % N);
      else
        cons_ptr = AW'(m_slot);
      send_frame(n, k, bad, both, tail);
      idle($urandom_range(0, 3));
    end
    idle(8);
    check("end_queue_empty", 64'(cq.size() + dq.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
